// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default lock timeout.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int LOCK_TO_DEFAULT = 1024;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    // A byte moves when its valid is high in the same cycle as the matching
    // one-cycle ready pulse; valid may drop without a transfer, ready alone means nothing.
    logic [N_REQ-1:0]   req_vld_i;
    logic [8*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]   req_last_i;
    logic [N_REQ-1:0]   req_rdy_o;
    logic [7:0]         tx_data_o;
    logic               tx_vld_o;
    logic               tx_rdy_i;
    logic [N_REQ-1:0]   grant_o;
    logic               lock_to_o;

    modport master (
        output req_vld_i, req_data_i, req_last_i, tx_rdy_i,
        input  req_rdy_o, tx_data_o, tx_vld_o, grant_o, lock_to_o
    );

    modport slave (
        input  req_vld_i, req_data_i, req_last_i, tx_rdy_i,
        output req_rdy_o, tx_data_o, tx_vld_o, grant_o, lock_to_o
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    int k;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        any_req = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any_req && req[IW'(k)]) begin
                any_req           = 1'b1;
                idx               = IW'(k);
                onehot[IW'(k)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N_REQ byte streams onto one UART transmitter with per-message locking.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LOCK_TO = LOCK_TO_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          cfg_en_i,
    uart_tx_arb_if.slave  bus,
    output state_e        state_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] LOCK_TO_C = CNT_W'(LOCK_TO);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_q, lock_d;

    logic [N_REQ-1:0]   pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic               owner_vld, owner_last, tx_vld, accept, timeout;
    logic [7:0]         owner_data;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IW-1:0]      ptr_inc;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req     (bus.req_vld_i),
        .ptr     (ptr_q),
        .onehot  (pick_oh),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign owner_vld  = bus.req_vld_i[gidx_q];
    assign owner_last = bus.req_last_i[gidx_q];
    assign owner_data = bus.req_data_i[{gidx_q, 3'b000} +: 8];
    assign tx_vld     = (state_q == ST_SEND) && owner_vld;
    assign accept     = tx_vld && bus.tx_rdy_i;

    // Idle counter saturates so a very long stall can never wrap past LOCK_TO.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timeout = (cnt_inc >= LOCK_TO_C);
    assign ptr_inc = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

    assign bus.tx_vld_o  = tx_vld;
    assign bus.tx_data_o = (state_q != ST_IDLE) ? owner_data : 8'h00;
    assign bus.req_rdy_o = accept ? grant_q : '0;
    assign bus.grant_o   = grant_q;
    assign bus.lock_to_o = lock_q;
    assign state_o       = state_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lock_d  = 1'b0;
        if (!cfg_en_i) begin
            state_d = ST_IDLE;
            grant_d = '0;
            gidx_d  = '0;
            ptr_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_d = ST_SEND;
                        grant_d = pick_oh;
                        gidx_d  = pick_idx;
                        cnt_d   = '0;
                    end
                end
                ST_SEND, ST_HOLD: begin
                    // A stalled SEND shares the HOLD idle counter and timeout.
                    if (accept && owner_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_inc;
                        cnt_d   = '0;
                    end else if (accept) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (owner_vld) begin
                        state_d = ST_SEND;
                        cnt_d   = '0;
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_inc;
                        cnt_d   = '0;
                        lock_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed scenarios plus randomized message traffic against a message-level round-robin model.
module tb_uart_tx_arb;
    import uart_tx_arb_pkg::*;

    localparam int N  = 4;
    localparam int LT = 20;
    localparam int W  = 16;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   cfg_en = 1'b0;
    state_e state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    logic [7:0] rb[N][16];
    logic       rl[N][16];
    int         rlen[N];
    int         rpos[N];
    int         gap[N];
    int         mpos[N];
    int         mptr = 0;

    uart_tx_arb_if #(.N_REQ(N)) bus();

    uart_tx_arb #(.N_REQ(N), .LOCK_TO(LT)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .cfg_en_i (cfg_en),
        .bus      (bus.slave),
        .state_o  (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic l, input logic [7:0] d);
        bus.req_vld_i[r]        = v;
        bus.req_last_i[r]       = l;
        bus.req_data_i[r*8 +: 8] = d;
    endtask

    task automatic chk_send(input string tag, input logic [N-1:0] g, input logic [7:0] d,
                            input logic [N-1:0] rdy);
        chk({tag, "_grant"}, bus.grant_o, g);
        chk({tag, "_vld"},   bus.tx_vld_o, 1);
        chk({tag, "_data"},  bus.tx_data_o, d);
        chk({tag, "_rdy"},   bus.req_rdy_o, rdy);
    endtask

    task automatic rnd_round();
        int found;
        int r;
        int remaining;
        logic [N-1:0] oh;
        logic [W-1:0] e;
        for (int q = 0; q < N; q++) begin
            int nm;
            rlen[q] = 0; rpos[q] = 0; gap[q] = 0; mpos[q] = 0;
            nm = $urandom_range(0, 3);
            for (int m = 0; m < nm; m++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    rb[q][rlen[q]] = 8'($urandom);
                    rl[q][rlen[q]] = (b == len - 1);
                    rlen[q]++;
                end
            end
        end
        // Expected stream: whole messages, one per owner, owners in round-robin order.
        for (int guard = 0; guard < 64; guard++) begin
            found = -1;
            for (int i = 0; i < N; i++) begin
                r = (mptr + i) % N;
                if (found < 0 && mpos[r] < rlen[r]) found = r;
            end
            if (found < 0) break;
            oh = '0;
            oh[found] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                logic lst;
                lst = rl[found][mpos[found]];
                exp_q.push_back({oh, oh, rb[found][mpos[found]]});
                mpos[found]++;
                if (lst) break;
            end
            mptr = (found + 1) % N;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int q = 0; q < N; q++) begin
                if (rpos[q] < rlen[q] && gap[q] == 0)
                    set_req(q, 1'b1, rl[q][rpos[q]], rb[q][rpos[q]]);
                else
                    set_req(q, 1'b0, 1'b0, 8'h00);
            end
            bus.tx_rdy_i = 1'($urandom_range(0, 1));
            at_neg();
            if (bus.tx_vld_o && bus.tx_rdy_i) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                chk("rnd_byte", {bus.grant_o, bus.req_rdy_o, bus.tx_data_o}, e);
            end else begin
                chk("rnd_no_rdy", bus.req_rdy_o, 0);
            end
            chk("rnd_no_lock", bus.lock_to_o, 0);
            for (int q = 0; q < N; q++)
                if (gap[q] > 0) gap[q]--;
            for (int q = 0; q < N; q++) begin
                if (bus.req_rdy_o[q] && rpos[q] < rlen[q]) begin
                    gap[q] = rl[q][rpos[q]] ? 0 : $urandom_range(0, 3);
                    rpos[q]++;
                end
            end
            at_pos();
            remaining = 0;
            for (int q = 0; q < N; q++) remaining += rlen[q] - rpos[q];
            if (remaining == 0 && exp_q.size() == 0) break;
        end
        remaining = 0;
        for (int q = 0; q < N; q++) remaining += rlen[q] - rpos[q];
        chk("rnd_drain", exp_q.size(), 0);
        chk("rnd_consumed", remaining, 0);
        exp_q.delete();
        for (int q = 0; q < N; q++) set_req(q, 1'b0, 1'b0, 8'h00);
        bus.tx_rdy_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed time limit reached, expected bench to finish");
        $fatal(1);
    end

    initial begin
        bus.req_vld_i  = '0;
        bus.req_last_i = '0;
        bus.req_data_i = '0;
        bus.tx_rdy_i   = 1'b0;
        rst_n  = 1'b0;
        cfg_en = 1'b1;
        repeat (3) @(posedge clk);
        at_neg();
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_vld",   bus.tx_vld_o, 0);
        chk("rst_rdy",   bus.req_rdy_o, 0);
        chk("rst_data",  bus.tx_data_o, 0);
        chk("rst_lock",  bus.lock_to_o, 0);
        chk("rst_state", state, ST_IDLE);
        at_pos();
        rst_n = 1'b1;

        // tx_rdy in IDLE is ignored
        bus.tx_rdy_i = 1'b1;
        at_neg();
        chk("idle_rdy_ignored", bus.req_rdy_o, 0);
        chk("idle_vld", bus.tx_vld_o, 0);
        at_pos();
        bus.tx_rdy_i = 1'b0;
        at_neg();
        chk("idle_state_kept", state, ST_IDLE);
        chk("idle_grant_kept", bus.grant_o, 0);

        // Requesters 0 and 2, single-byte messages, ptr starts at 0
        at_pos();
        set_req(0, 1'b1, 1'b1, 8'hA0);
        set_req(2, 1'b1, 1'b1, 8'hA2);
        bus.tx_rdy_i = 1'b1;
        at_neg();
        chk("rr_idle_grant", bus.grant_o, 0);
        at_pos(); at_neg();
        chk_send("rr_first", 4'b0001, 8'hA0, 4'b0001);
        at_pos();
        set_req(0, 1'b0, 1'b0, 8'h00);
        at_neg();
        chk("rr_gap_grant", bus.grant_o, 0);
        chk("rr_gap_vld", bus.tx_vld_o, 0);
        at_pos(); at_neg();
        chk_send("rr_second", 4'b0100, 8'hA2, 4'b0100);
        at_pos();
        set_req(2, 1'b0, 1'b0, 8'h00);
        set_req(0, 1'b1, 1'b1, 8'hB0);
        set_req(3, 1'b1, 1'b1, 8'hB3);
        at_neg();
        at_pos(); at_neg();
        chk_send("rr_ptr3", 4'b1000, 8'hB3, 4'b1000);
        at_pos();
        set_req(3, 1'b0, 1'b0, 8'h00);
        at_neg();
        at_pos(); at_neg();
        chk_send("rr_wrap", 4'b0001, 8'hB0, 4'b0001);
        at_pos();
        set_req(0, 1'b0, 1'b0, 8'h00);

        // Requester 1 three-byte message locks out requester 3 (ptr now 1)
        set_req(1, 1'b1, 1'b0, 8'hC0);
        set_req(3, 1'b1, 1'b1, 8'hD3);
        at_neg();
        chk("msg_idle_grant", bus.grant_o, 0);
        at_pos(); at_neg();
        chk_send("msg_b0", 4'b0010, 8'hC0, 4'b0010);
        at_pos();
        set_req(1, 1'b1, 1'b0, 8'hC1);
        at_neg();
        chk("msg_hold_vld", bus.tx_vld_o, 0);
        chk("msg_hold_grant", bus.grant_o, 4'b0010);
        at_pos(); at_neg();
        chk_send("msg_b1", 4'b0010, 8'hC1, 4'b0010);
        at_pos();
        set_req(1, 1'b1, 1'b1, 8'hC2);
        at_neg();
        chk("msg_hold2_grant", bus.grant_o, 4'b0010);
        at_pos(); at_neg();
        chk_send("msg_b2", 4'b0010, 8'hC2, 4'b0010);
        at_pos();
        set_req(1, 1'b0, 1'b0, 8'h00);
        at_neg();
        chk("msg_release", bus.grant_o, 0);
        at_pos(); at_neg();
        chk_send("msg_next_owner", 4'b1000, 8'hD3, 4'b1000);
        at_pos();
        set_req(3, 1'b0, 1'b0, 8'h00);

        // Lock timeout: requester 1 stalls mid-message for LT cycles (ptr now 0)
        set_req(1, 1'b1, 1'b0, 8'hE1);
        set_req(2, 1'b1, 1'b1, 8'hE2);
        at_neg();
        at_pos(); at_neg();
        chk_send("lto_first", 4'b0010, 8'hE1, 4'b0010);
        at_pos();
        set_req(1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < LT; k++) begin
            at_neg();
            chk("lto_held_grant", bus.grant_o, 4'b0010);
            chk("lto_no_pulse", bus.lock_to_o, 0);
            at_pos();
        end
        at_neg();
        chk("lto_pulse", bus.lock_to_o, 1);
        chk("lto_grant_cleared", bus.grant_o, 0);
        at_pos(); at_neg();
        chk("lto_pulse_one_cycle", bus.lock_to_o, 0);
        chk_send("lto_next", 4'b0100, 8'hE2, 4'b0100);
        at_pos();
        set_req(2, 1'b0, 1'b0, 8'h00);
        bus.tx_rdy_i = 1'b0;

        // Disable during SEND (ptr now 3)
        set_req(0, 1'b1, 1'b1, 8'hF0);
        at_neg();
        at_pos(); at_neg();
        chk_send("dis_send", 4'b0001, 8'hF0, 4'b0000);
        at_pos();
        cfg_en = 1'b0;
        at_neg();
        at_pos(); at_neg();
        chk("dis_grant", bus.grant_o, 0);
        chk("dis_vld", bus.tx_vld_o, 0);
        chk("dis_state", state, ST_IDLE);
        at_pos();
        cfg_en = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h50);
        set_req(3, 1'b1, 1'b1, 8'h13);
        bus.tx_rdy_i = 1'b1;
        at_neg();
        chk("en_idle_grant", bus.grant_o, 0);
        at_pos(); at_neg();
        chk_send("en_ptr0", 4'b0001, 8'h50, 4'b0001);

        // Reset in the middle of requester 0's message
        at_pos();
        set_req(0, 1'b1, 1'b0, 8'h51);
        at_neg();
        chk("mid_hold_vld", bus.tx_vld_o, 0);
        at_pos(); at_neg();
        chk_send("mid_send", 4'b0001, 8'h51, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", bus.grant_o, 0);
        chk("mid_rst_vld",   bus.tx_vld_o, 0);
        chk("mid_rst_rdy",   bus.req_rdy_o, 0);
        chk("mid_rst_data",  bus.tx_data_o, 0);
        chk("mid_rst_lock",  bus.lock_to_o, 0);
        at_pos();
        set_req(0, 1'b1, 1'b1, 8'h51);
        at_neg();
        chk("mid_rst_rdy_held", bus.req_rdy_o, 0);
        at_pos();
        rst_n = 1'b1;
        at_neg();
        chk("resub_idle", bus.grant_o, 0);
        at_pos(); at_neg();
        chk_send("resub", 4'b0001, 8'h51, 4'b0001);
        at_pos();
        set_req(0, 1'b0, 1'b0, 8'h00);
        at_neg();
        at_pos(); at_neg();
        chk_send("resub_other", 4'b1000, 8'h13, 4'b1000);
        at_pos();
        set_req(3, 1'b0, 1'b0, 8'h00);
        bus.tx_rdy_i = 1'b0;

        // Clear the pointer, then random message traffic
        cfg_en = 1'b0;
        at_pos();
        cfg_en = 1'b1;
        mptr = 0;
        for (int round = 0; round < 6; round++) rnd_round();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requester streams (2..8).
REQ-002 SHALL have parameter LOCK_TO, default 1024, idle cycles after which a locked grant is released (1..65535).
REQ-003 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_en_i  input  1  arbiter enable.
REQ-006 SHALL have port req_vld_i  input  N_REQ  per-requester byte valid.
REQ-007 SHALL have port req_data_i  input  8*N_REQ  per-requester byte, requester k on bits [8k+7:8k].
REQ-008 SHALL have port req_last_i  input  N_REQ  per-requester last byte of message, qualified by req_vld_i.
REQ-009 SHALL have port req_rdy_o  output  N_REQ  per-requester byte accepted, one-cycle pulse.
REQ-010 SHALL have port tx_data_o  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_vld_o  output  1  byte valid to UART transmitter.
REQ-012 SHALL have port tx_rdy_i  input  1  UART transmitter accepted byte, one-cycle pulse.
REQ-013 SHALL have port grant_o  output  N_REQ  one-hot current owner, all-zero when none.
REQ-014 SHALL have port lock_to_o  output  1  one-cycle pulse when a lock is released by timeout.

Function
REQ-015 SHALL implement states IDLE, SEND, HOLD.
REQ-016 IDLE: grant_o=0, tx_vld_o=0; any req_vld_i bit set -> register winner into grant_o, go SEND next cycle.
REQ-017 Winner SHALL be the first set req_vld_i bit searching from round-robin pointer ptr upward, wrapping N_REQ-1 -> 0.
REQ-018 SEND: tx_vld_o = req_vld_i[g], tx_data_o = req_data_i[g] (combinational mux of owner g); tx_data_o=0 when no owner.
REQ-019 req_rdy_o[g] SHALL equal tx_rdy_i AND tx_vld_o AND state SEND; all other bits 0.
REQ-020 Acceptance with req_last_i[g]=1: go IDLE, grant_o<=0, ptr<=g+1 mod N_REQ.
REQ-021 Acceptance with req_last_i[g]=0: go HOLD, grant retained (message lock).
REQ-022 HOLD: tx_vld_o=0; req_vld_i[g]=1 -> SEND next cycle, timeout counter cleared.
REQ-023 HOLD: req_vld_i[g]=0 counts idle cycles; count reaching LOCK_TO -> IDLE, grant_o<=0, ptr<=g+1, lock_to_o pulse one cycle.
REQ-024 SEND with req_vld_i[g] dropped before acceptance SHALL behave as HOLD counting (same counter, same timeout).
REQ-025 tx_rdy_i while tx_vld_o=0 SHALL be ignored (no req_rdy_o, no state change).
REQ-026 Requests from non-owners SHALL not affect grant until return to IDLE; minimum one IDLE cycle between owners.
REQ-027 cfg_en_i=0 SHALL force IDLE, grant_o=0, tx_vld_o=0, counter=0, ptr=0 on next edge; cfg_en_i=1 resumes from IDLE.
REQ-028 Timeout counter SHALL be 16 bits, saturating, never wrapping.

Reset
REQ-029 Reset SHALL set state IDLE, ptr=0, counter=0, grant_o=0, lock_to_o=0; tx_vld_o, req_rdy_o, tx_data_o therefore 0.
REQ-030 Reset mid-message SHALL drop the lock with no req_rdy_o pulse; requester resubmits.

Structure
REQ-031 State encodings and the default LOCK_TO constant SHALL live in the shared uart package.
REQ-032 Round-robin winner search SHALL be one sub-module, rr_pick (inputs request vector, pointer; outputs one-hot, index, any).

Verification
REQ-033 Reqs 0 and 2 valid, last=1, ptr=0 -> grant 0 first, then 2; ptr=3 after second acceptance.
REQ-034 Req 1 sends 3 bytes (last on third), req 3 valid throughout -> bytes 1,1,1 contiguous, then req 3 granted.
REQ-035 Req 1 last=0 then valid low for LOCK_TO cycles -> lock_to_o pulse at cycle LOCK_TO, grant_o=0, req 2 next.
REQ-036 tx_rdy_i pulsed in IDLE -> req_rdy_o stays 0, state unchanged.
REQ-037 cfg_en_i deasserted during SEND -> grant_o=0, tx_vld_o=0 next cycle; re-enable, req 0 wins from ptr=0.
REQ-038 rst_n_i asserted mid-message -> all outputs 0 immediately, no req_rdy_o pulse.
